test_ctrl: RTL and testbench

Memory-mapped test controller on the core's data-memory bus, generalising fixed-delay, hard-coded-register simulation checks into a parametrised, program-driven pass/fail/timeout mechanism. Firmware reports completion by writing a TOHOST word and may deposit up to NUM_SIG signature words. The block counts cycles and retired instructions, enforces a cycle timeout and raises a sticky halt to the core. Benches poll `done`/`pass`/`fail_code` instead of sampling register-file internals after a fixed delay.

---
 rtl/test_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_test_ctrl.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/test_ctrl.sv
// test_ctrl: memory-mapped test controller that sits on the core's data bus.
// Firmware finishes a run by writing TOHOST. This block counts RUN cycles and
// retired instructions, enforces an optional cycle timeout, keeps signature
// words, and raises a sticky halt so benches can poll done/pass/fail_code.
module test_ctrl #(
   parameter logic [31:0] BASE_ADDR      = 32'h8000_0000,
   parameter int unsigned NUM_SIG        = 4,
   parameter int unsigned CNT_WIDTH      = 48,
   parameter int unsigned TIMEOUT_CYCLES = 1000
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic                 retire,
   input  logic [31:0]          bus_addr,
   input  logic [31:0]          bus_wdata,
   input  logic                 bus_we,
   output logic [31:0]          bus_rdata,
   output logic                 bus_sel,
   output logic                 halt,
   output logic                 done,
   output logic                 pass,
   output logic                 timed_out,
   output logic [30:0]          fail_code,
   output logic [CNT_WIDTH-1:0] cycle_count
);

   // Run states; the numeric encoding is what firmware sees in STATUS[2:0]
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RUN     = 3'd1,
      ST_PASS    = 3'd2,
      ST_FAIL    = 3'd3,
      ST_TIMEOUT = 3'd4
   } state_t;

   // Word offsets inside the 4 KiB register window
   localparam logic [9:0] OFF_TOHOST     = 10'd0;
   localparam logic [9:0] OFF_CYCLE_LO   = 10'd1;
   localparam logic [9:0] OFF_CYCLE_HI   = 10'd2;
   localparam logic [9:0] OFF_INSTRET_LO = 10'd3;
   localparam logic [9:0] OFF_STATUS     = 10'd4;
   localparam logic [9:0] OFF_SIG0       = 10'd8;

   localparam int unsigned SIG_IW = (NUM_SIG > 1) ? $clog2(NUM_SIG) : 1;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] TO_LIMIT  = CNT_WIDTH'(TIMEOUT_CYCLES);
   localparam logic [CNT_WIDTH-1:0] TO_LAST   = TO_LIMIT - CNT_ONE;
   localparam logic                 TO_ENABLE = (TIMEOUT_CYCLES != 0);

   state_t                r_state;
   logic [CNT_WIDTH-1:0]  r_cycleCount;
   logic [CNT_WIDTH-1:0]  r_instret;
   logic [30:0]           r_failCode;
   logic                  r_halt;
   logic                  r_pass;
   logic                  r_timedOut;
   logic [31:0]           r_sig [NUM_SIG];

   logic                  w_sel;
   logic [9:0]            w_wordIdx;
   logic [9:0]            w_sigOffset;
   logic [SIG_IW-1:0]     w_sigIdx;
   logic                  w_sigHit;
   logic                  w_busWrite;
   logic                  w_finish;
   logic                  w_timeoutHit;
   logic                  w_cycleSat;
   logic                  w_instretSat;
   logic [63:0]           w_cycle64;
   logic [63:0]           w_instret64;
   logic [31:0]           w_rdata;
   logic                  w_unused;

   // The window is 4 KiB aligned, so only the upper address bits select it;
   // the byte lane bits are dropped because all accesses are whole words
   assign w_sel       = (bus_addr[31:12] == BASE_ADDR[31:12]);
   assign w_wordIdx   = bus_addr[11:2];
   assign w_sigOffset = w_wordIdx - OFF_SIG0;
   assign w_sigIdx    = w_sigOffset[SIG_IW-1:0];
   assign w_sigHit    = (w_wordIdx >= OFF_SIG0) &&
                        (w_wordIdx < (OFF_SIG0 + 10'(NUM_SIG)));
   assign w_busWrite  = w_sel && bus_we;

   // A finishing write is a TOHOST write with bit 0 set while running
   assign w_finish     = (r_state == ST_RUN) && w_busWrite &&
                         (w_wordIdx == OFF_TOHOST) && bus_wdata[0];
   assign w_timeoutHit = TO_ENABLE && (r_cycleCount == TO_LAST);
   assign w_cycleSat   = &r_cycleCount;
   assign w_instretSat = &r_instret;

   assign w_cycle64   = 64'(r_cycleCount);
   assign w_instret64 = 64'(r_instret);

   assign w_unused = &{1'b0, bus_addr[1:0], w_sigOffset[9:SIG_IW],
                       w_instret64[63:32]};

   // Run-control FSM with its counters and registered status outputs; every
   // status flag changes on the same edge as the state it reflects
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= ST_IDLE;
         r_cycleCount <= '0;
         r_instret    <= '0;
         r_failCode   <= '0;
         r_halt       <= 1'b0;
         r_pass       <= 1'b0;
         r_timedOut   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state      <= ST_RUN;
                  r_cycleCount <= '0;
                  r_instret    <= '0;
               end
            end
            ST_RUN: begin
               if (!w_cycleSat) begin
                  r_cycleCount <= r_cycleCount + CNT_ONE;
               end
               if (retire && !w_instretSat) begin
                  r_instret <= r_instret + CNT_ONE;
               end
               if (w_finish) begin
                  r_halt <= 1'b1;
                  if (bus_wdata[31:1] == 31'd0) begin
                     r_state <= ST_PASS;
                     r_pass  <= 1'b1;
                  end else begin
                     r_state    <= ST_FAIL;
                     r_failCode <= bus_wdata[31:1];
                  end
               end else if (w_timeoutHit) begin
                  r_state    <= ST_TIMEOUT;
                  r_halt     <= 1'b1;
                  r_timedOut <= 1'b1;
               end
            end
            default: begin
               r_state <= r_state;
            end
         endcase
      end
   end

   // Signature words are writable only while the program is running so a
   // finished run's signature cannot be disturbed afterwards
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(NUM_SIG); i++) begin
            r_sig[i] <= '0;
         end
      end else if ((r_state == ST_RUN) && w_busWrite && w_sigHit) begin
         r_sig[w_sigIdx] <= bus_wdata;
      end
   end

   // Read mux: TOHOST and unmapped in-window words read as zero, and nothing
   // is driven onto the bus when the address lies outside the window
   always_comb begin
      w_rdata = 32'd0;
      if (w_sel) begin
         case (w_wordIdx)
            OFF_TOHOST:     w_rdata = 32'd0;
            OFF_CYCLE_LO:   w_rdata = w_cycle64[31:0];
            OFF_CYCLE_HI:   w_rdata = w_cycle64[63:32];
            OFF_INSTRET_LO: w_rdata = w_instret64[31:0];
            OFF_STATUS:     w_rdata = {29'd0, r_state};
            default: begin
               if (w_sigHit) begin
                  w_rdata = r_sig[w_sigIdx];
               end
            end
         endcase
      end
   end

   assign bus_sel     = w_sel;
   assign bus_rdata   = w_rdata;
   assign halt        = r_halt;
   assign done        = r_halt;
   assign pass        = r_pass;
   assign timed_out   = r_timedOut;
   assign fail_code   = r_failCode;
   assign cycle_count = r_cycleCount;

endmodule

// File: tb/tb_test_ctrl.sv
// tb_test_ctrl: directed bench for test_ctrl covering pass, fail, timeout,
// write-versus-timeout priority, the register map and instret counting.
module tb_test_ctrl;

   localparam logic [31:0] BASE = 32'h8000_0000;
   localparam int CW = 48;

   logic          clk;
   logic          reset_n;
   logic          start;
   logic          retire;
   logic [31:0]   bus_addr;
   logic [31:0]   bus_wdata;
   logic          bus_we;
   logic [31:0]   bus_rdata;
   logic          bus_sel;
   logic          halt;
   logic          done;
   logic          pass;
   logic          timed_out;
   logic [30:0]   fail_code;
   logic [CW-1:0] cycle_count;

   int assertCount;
   int failCount;

   test_ctrl #(
      .BASE_ADDR      (BASE),
      .NUM_SIG        (4),
      .CNT_WIDTH      (CW),
      .TIMEOUT_CYCLES (20)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .retire      (retire),
      .bus_addr    (bus_addr),
      .bus_wdata   (bus_wdata),
      .bus_we      (bus_we),
      .bus_rdata   (bus_rdata),
      .bus_sel     (bus_sel),
      .halt        (halt),
      .done        (done),
      .pass        (pass),
      .timed_out   (timed_out),
      .fail_code   (fail_code),
      .cycle_count (cycle_count)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reset and return to a falling edge so the next stimulus is away from posedge
   task automatic doReset();
      start     = 1'b0;
      retire    = 1'b0;
      bus_we    = 1'b0;
      bus_addr  = 32'd0;
      bus_wdata = 32'd0;
      reset_n   = 1'b0;
      #2;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   // Leaves the bench one falling edge after the IDLE->RUN edge (count 0)
   task automatic startRun();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // One bus write, sampled by exactly one rising edge
   task automatic writeReg(input logic [11:0] off, input logic [31:0] data);
      bus_addr  = BASE + {20'd0, off};
      bus_wdata = data;
      bus_we    = 1'b1;
      @(negedge clk);
      bus_we = 1'b0;
   endtask

   // Combinational read, no clock edge consumed
   task automatic readReg(input logic [11:0] off, output logic [31:0] data);
      bus_we   = 1'b0;
      bus_addr = BASE + {20'd0, off};
      #1;
      data = bus_rdata;
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      start     = 1'b0;
      retire    = 1'b0;
      bus_we    = 1'b0;
      bus_wdata = 32'd0;
      bus_addr  = 32'd0;
      reset_n   = 1'b0;
      #1;
      assertCount++;
      if ({halt, done, pass, timed_out} !== 4'b0000) begin
         failCount++;
         $display("[TB] FAIL reset_flags got %b want 0000", {halt, done, pass, timed_out});
      end
      assertCount++;
      if (fail_code !== 31'd0 || cycle_count !== '0) begin
         failCount++;
         $display("[TB] FAIL reset_counts got code=%0d cyc=%0d want 0/0", fail_code, cycle_count);
      end
      readReg(12'h010, rd);
      assertCount++;
      if (rd !== 32'd0) begin
         failCount++;
         $display("[TB] FAIL reset_status got %h want 0", rd);
      end
      doReset();
   endtask

   task automatic test_pass();
      logic [31:0] rd;
      doReset();
      startRun();
      repeat (10) @(negedge clk);
      writeReg(12'h000, 32'h1);
      assertCount++;
      if ({halt, done, pass, timed_out} !== 4'b1110) begin
         failCount++;
         $display("[TB] FAIL pass_flags got %b want 1110", {halt, done, pass, timed_out});
      end
      assertCount++;
      if (cycle_count !== 48'd11) begin
         failCount++;
         $display("[TB] FAIL pass_cycles got %0d want 11", cycle_count);
      end
      assertCount++;
      if (fail_code !== 31'd0) begin
         failCount++;
         $display("[TB] FAIL pass_code got %0d want 0", fail_code);
      end
      readReg(12'h010, rd);
      assertCount++;
      if (rd !== 32'd2) begin
         failCount++;
         $display("[TB] FAIL pass_status got %h want 2", rd);
      end
      writeReg(12'h000, 32'h7);
      @(negedge clk);
      assertCount++;
      if (pass !== 1'b1 || fail_code !== 31'd0 || cycle_count !== 48'd11) begin
         failCount++;
         $display("[TB] FAIL pass_sticky got pass=%b code=%0d cyc=%0d want 1/0/11",
                  pass, fail_code, cycle_count);
      end
   endtask

   task automatic test_fail();
      logic [31:0] rd;
      doReset();
      startRun();
      writeReg(12'h000, 32'h14);
      readReg(12'h010, rd);
      assertCount++;
      if (rd !== 32'd1 || halt !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL fail_bit0clear got status=%h halt=%b want 1/0", rd, halt);
      end
      writeReg(12'h000, 32'h15);
      assertCount++;
      if (fail_code !== 31'd10 || pass !== 1'b0 || halt !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL fail_result got code=%0d pass=%b halt=%b want 10/0/1",
                  fail_code, pass, halt);
      end
      assertCount++;
      if (cycle_count !== 48'd2) begin
         failCount++;
         $display("[TB] FAIL fail_cycles got %0d want 2", cycle_count);
      end
      start = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         assertCount++;
         if (halt !== 1'b1 || fail_code !== 31'd10) begin
            failCount++;
            $display("[TB] FAIL fail_sticky cycle %0d got halt=%b code=%0d want 1/10",
                     i, halt, fail_code);
         end
      end
      start = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      assertCount++;
      if (halt !== 1'b0 || fail_code !== 31'd0) begin
         failCount++;
         $display("[TB] FAIL fail_asyncreset got halt=%b code=%0d want 0/0", halt, fail_code);
      end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_timeout();
      logic [31:0] rd;
      doReset();
      startRun();
      repeat (19) @(negedge clk);
      assertCount++;
      if (timed_out !== 1'b0 || cycle_count !== 48'd19) begin
         failCount++;
         $display("[TB] FAIL timeout_early got to=%b cyc=%0d want 0/19", timed_out, cycle_count);
      end
      @(negedge clk);
      assertCount++;
      if ({halt, pass, timed_out} !== 3'b101 || cycle_count !== 48'd20) begin
         failCount++;
         $display("[TB] FAIL timeout_hit got hpt=%b cyc=%0d want 101/20",
                  {halt, pass, timed_out}, cycle_count);
      end
      readReg(12'h010, rd);
      assertCount++;
      if (rd !== 32'd4) begin
         failCount++;
         $display("[TB] FAIL timeout_status got %h want 4", rd);
      end
      repeat (5) @(negedge clk);
      assertCount++;
      if (cycle_count !== 48'd20) begin
         failCount++;
         $display("[TB] FAIL timeout_frozen got %0d want 20", cycle_count);
      end
   endtask

   task automatic test_write_beats_timeout();
      doReset();
      startRun();
      repeat (19) @(negedge clk);
      writeReg(12'h000, 32'h1);
      assertCount++;
      if (pass !== 1'b1 || timed_out !== 1'b0 || cycle_count !== 48'd20) begin
         failCount++;
         $display("[TB] FAIL priority got pass=%b to=%b cyc=%0d want 1/0/20",
                  pass, timed_out, cycle_count);
      end
   endtask

   task automatic test_regmap();
      logic [31:0] rd;
      doReset();
      writeReg(12'h028, 32'h1234_5678);
      readReg(12'h028, rd);
      assertCount++;
      if (rd !== 32'd0) begin
         failCount++;
         $display("[TB] FAIL sig_idle_write got %h want 0", rd);
      end
      startRun();
      writeReg(12'h028, 32'hDEAD_BEEF);
      readReg(12'h028, rd);
      assertCount++;
      if (rd !== 32'hDEAD_BEEF) begin
         failCount++;
         $display("[TB] FAIL sig2_read got %h want deadbeef", rd);
      end
      readReg(12'h02A, rd);
      assertCount++;
      if (rd !== 32'hDEAD_BEEF) begin
         failCount++;
         $display("[TB] FAIL sig2_byteoff got %h want deadbeef", rd);
      end
      writeReg(12'h004, 32'h5555_5555);
      readReg(12'h004, rd);
      assertCount++;
      if (rd !== 32'd2) begin
         failCount++;
         $display("[TB] FAIL cycle_lo_ro got %h want 2", rd);
      end
      writeReg(12'h02C, 32'h0000_0BAD);
      writeReg(12'h000, 32'h1);
      writeReg(12'h02C, 32'hFFFF_FFFF);
      readReg(12'h02C, rd);
      assertCount++;
      if (rd !== 32'h0000_0BAD) begin
         failCount++;
         $display("[TB] FAIL sig3_postpass got %h want 00000bad", rd);
      end
      readReg(12'h020, rd);
      assertCount++;
      if (rd !== 32'd0) begin
         failCount++;
         $display("[TB] FAIL sig0_read got %h want 0", rd);
      end
      readReg(12'h008, rd);
      assertCount++;
      if (rd !== 32'd0) begin
         failCount++;
         $display("[TB] FAIL cycle_hi got %h want 0", rd);
      end
      readReg(12'h000, rd);
      assertCount++;
      if (rd !== 32'd0) begin
         failCount++;
         $display("[TB] FAIL tohost_read got %h want 0", rd);
      end
      readReg(12'h030, rd);
      assertCount++;
      if (rd !== 32'd0) begin
         failCount++;
         $display("[TB] FAIL sig_beyond got %h want 0", rd);
      end
      readReg(12'h100, rd);
      assertCount++;
      if (rd !== 32'd0 || bus_sel !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL unmapped got rd=%h sel=%b want 0/1", rd, bus_sel);
      end
      bus_addr = BASE - 32'd4;
      #1;
      assertCount++;
      if (bus_sel !== 1'b0 || bus_rdata !== 32'd0) begin
         failCount++;
         $display("[TB] FAIL outside got sel=%b rd=%h want 0/0", bus_sel, bus_rdata);
      end
      bus_addr = BASE + 32'h0000_1000;
      #1;
      assertCount++;
      if (bus_sel !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL above_window got sel=%b want 0", bus_sel);
      end
   endtask

   task automatic test_instret();
      logic [31:0] rd;
      doReset();
      retire = 1'b1;
      repeat (3) @(negedge clk);
      retire = 1'b0;
      startRun();
      for (int i = 0; i < 7; i++) begin
         retire = 1'b1;
         @(negedge clk);
         retire = 1'b0;
         @(negedge clk);
      end
      readReg(12'h00C, rd);
      assertCount++;
      if (rd !== 32'd7) begin
         failCount++;
         $display("[TB] FAIL instret got %0d want 7", rd);
      end
      assertCount++;
      if (cycle_count !== 48'd14) begin
         failCount++;
         $display("[TB] FAIL instret_cycles got %0d want 14", cycle_count);
      end
      #1;
      reset_n = 1'b0;
      #1;
      assertCount++;
      if ({halt, done, pass, timed_out} !== 4'b0000 || fail_code !== 31'd0 ||
          cycle_count !== '0) begin
         failCount++;
         $display("[TB] FAIL midrun_reset got flags=%b code=%0d cyc=%0d want 0",
                  {halt, done, pass, timed_out}, fail_code, cycle_count);
      end
      readReg(12'h00C, rd);
      assertCount++;
      if (rd !== 32'd0) begin
         failCount++;
         $display("[TB] FAIL midrun_instret got %0d want 0", rd);
      end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   // Run every scenario in order, then report
   initial begin
      assertCount = 0;
      failCount   = 0;
      test_reset();
      test_pass();
      test_fail();
      test_timeout();
      test_write_beats_timeout();
      test_regmap();
      test_instret();
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
